// File: rtl/cobs_decode.sv
// Receive-side COBS deframer: 0x00-delimited COBS blocks in, decoded payload bytes out.
// A one-byte hold register delays each byte until its successor or the delimiter arrives, so o_last is exact.
module cobs_decode #(
    parameter int DW            = 8,
    parameter bit SYNC_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_last,
    output logic          o_err
);

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_CODE = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [DW-1:0] ONE  = DW'(1);
    localparam logic [DW-1:0] ALL1 = '1;

    logic [1:0]    state_reg, state_next;
    logic [DW-1:0] cnt_reg, cnt_next;
    logic          ff_reg, ff_next;
    logic          pend_zero_reg, pend_zero_next;
    logic [DW-1:0] hold_reg, hold_next;
    logic          hold_valid_reg, hold_valid_next;
    logic [DW-1:0] out_data_reg, out_data_next;
    logic          out_last_reg, out_last_next;
    logic          out_valid_reg, out_valid_next;
    logic          err_reg, err_next;

    logic          accept;
    logic          in_zero;
    logic          push_en;
    logic [DW-1:0] push_byte;
    logic          flush_en;

    assign o_ready = ~out_valid_reg | i_ready;
    assign accept  = i_valid & o_ready;
    assign in_zero = (i_data == '0);

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        ff_next         = ff_reg;
        pend_zero_next  = pend_zero_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        out_data_next   = out_data_reg;
        out_last_next   = out_last_reg;
        out_valid_next  = out_valid_reg & ~i_ready;
        err_next        = 1'b0;
        push_en         = 1'b0;
        push_byte       = '0;
        flush_en        = 1'b0;

        if (accept) begin
            case (state_reg)
                ST_SYNC: begin
                    if (in_zero) state_next = ST_CODE;
                end
                ST_CODE: begin
                    if (in_zero) begin
                        flush_en       = 1'b1;
                        pend_zero_next = 1'b0;
                    end else begin
                        // The zero implied by the previous block is only real once another code byte shows up
                        if (pend_zero_reg) begin
                            push_en   = 1'b1;
                            push_byte = '0;
                        end
                        cnt_next = i_data - ONE;
                        ff_next  = (i_data == ALL1);
                        if (i_data == ONE) begin
                            pend_zero_next = 1'b1;
                        end else begin
                            pend_zero_next = 1'b0;
                            state_next     = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (in_zero) begin
                        flush_en       = 1'b1;
                        err_next       = 1'b1;
                        pend_zero_next = 1'b0;
                        state_next     = ST_CODE;
                    end else begin
                        push_en   = 1'b1;
                        push_byte = i_data;
                        cnt_next  = cnt_reg - ONE;
                        if (cnt_reg == ONE) begin
                            pend_zero_next = ~ff_reg;
                            state_next     = ST_CODE;
                        end
                    end
                end
                default: state_next = ST_CODE;
            endcase
        end

        // An accept implies the output register is free this cycle, so moving hold->output never drops data
        if (push_en) begin
            if (hold_valid_reg) begin
                out_data_next  = hold_reg;
                out_last_next  = 1'b0;
                out_valid_next = 1'b1;
            end
            hold_next       = push_byte;
            hold_valid_next = 1'b1;
        end
        if (flush_en && hold_valid_reg) begin
            out_data_next   = hold_reg;
            out_last_next   = 1'b1;
            out_valid_next  = 1'b1;
            hold_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= SYNC_ON_RESET ? ST_SYNC : ST_CODE;
            cnt_reg        <= '0;
            ff_reg         <= 1'b0;
            pend_zero_reg  <= 1'b0;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            out_data_reg   <= '0;
            out_last_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            ff_reg         <= ff_next;
            pend_zero_reg  <= pend_zero_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            out_data_reg   <= out_data_next;
            out_last_reg   <= out_last_next;
            out_valid_reg  <= out_valid_next;
            err_reg        <= err_next;
        end
    end

    assign o_data  = out_data_reg;
    assign o_last  = out_last_reg;
    assign o_valid = out_valid_reg;
    assign o_err   = err_reg;

endmodule

// File: tb/tb_cobs_decode.sv
// Scoreboard bench for cobs_decode: a frame-level COBS reference model fills the expected queue,
// an independent monitor checks every output handshake, error pulse and backpressure behaviour.
module tb_cobs_decode;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] i_data = '0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready = 1'b1;
    logic       o_last;
    logic       o_err;

    cobs_decode #(.DW(8), .SYNC_ON_RESET(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_last  (o_last),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic [8:0] exp_q[$];
    int         exp_err = 0;
    int         err_seen = 0;

    bit         model_synced = 0;
    logic [7:0] frame_buf[$];

    int hold_low = 0;
    bit random_ready = 0;

    // Decode one complete frame (bytes between delimiters) straight from the COBS rules
    function automatic void model_frame(input logic [7:0] f[$]);
        logic [8:0] outq[$];
        int i = 0;
        bit trunc = 0;
        while (i < f.size() && !trunc) begin
            int c = int'(f[i]);
            i++;
            for (int k = 1; k < c; k++) begin
                if (i < f.size()) begin
                    outq.push_back({1'b0, f[i]});
                    i++;
                end else begin
                    trunc = 1;
                    break;
                end
            end
            if (!trunc && c != 255 && i < f.size()) outq.push_back(9'h000);
        end
        if (outq.size() > 0) outq[outq.size()-1][8] = 1'b1;
        foreach (outq[j]) exp_q.push_back(outq[j]);
        if (trunc) exp_err++;
    endfunction

    function automatic void model_stream(input logic [7:0] s[$]);
        foreach (s[j]) begin
            if (!model_synced) begin
                if (s[j] == 8'h00) model_synced = 1;
            end else if (s[j] == 8'h00) begin
                model_frame(frame_buf);
                frame_buf.delete();
            end else begin
                frame_buf.push_back(s[j]);
            end
        end
    endfunction

    // Backpressure source; changes away from both clock edges
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (hold_low > 0) begin
                i_ready = 1'b0;
                hold_low--;
            end else if (random_ready) begin
                i_ready = ($urandom_range(0, 3) != 0);
            end else begin
                i_ready = 1'b1;
            end
        end
    end

    // Monitor: sampled on the falling edge
    bit         prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;
    bit         prev_err = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 0;
                prev_err = 0;
            end else begin
                if (prev_stall) begin
                    compared++;
                    if (!(o_valid && o_data == prev_data && o_last == prev_last)) begin
                        mismatched++;
                        $display("FAIL stall_hold: got valid=%0b data=%02h last=%0b, need valid=1 data=%02h last=%0b",
                                 o_valid, o_data, o_last, prev_data, prev_last);
                    end
                end
                if (o_valid) begin
                    compared++;
                    if (o_ready !== i_ready) begin
                        mismatched++;
                        $display("FAIL o_ready: got %0b with o_valid=1 i_ready=%0b, need %0b", o_ready, i_ready, i_ready);
                    end
                end
                if (o_valid && i_ready) begin
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL out_byte: got data=%02h last=%0b, need no output", o_data, o_last);
                    end else begin
                        logic [8:0] e;
                        e = exp_q.pop_front();
                        if ({o_last, o_data} !== e) begin
                            mismatched++;
                            $display("FAIL out_byte: got data=%02h last=%0b, need data=%02h last=%0b",
                                     o_data, o_last, e[7:0], e[8]);
                        end else begin
                            $display("out data=%02h last=%0b ok", o_data, o_last);
                        end
                    end
                end
                if (o_err) begin
                    err_seen++;
                    compared++;
                    if (prev_err) begin
                        mismatched++;
                        $display("FAIL err_width: got o_err high 2+ cycles, need 1-cycle pulse");
                    end
                end
                prev_err   = o_err;
                prev_stall = o_valid && !i_ready;
                prev_data  = o_data;
                prev_last  = o_last;
            end
        end
    end

    task automatic send_stream(input logic [7:0] s[$], input int stall_at);
        model_stream(s);
        foreach (s[j]) begin
            bit acc;
            int guard;
            if (j == stall_at) hold_low = 5;
            i_data  = s[j];
            i_valid = 1'b1;
            acc = 0;
            guard = 0;
            while (!acc) begin
                @(negedge clk);
                acc = o_ready;
                @(posedge clk);
                #1;
                guard++;
                if (!acc && guard > 1000) begin
                    mismatched++;
                    $display("FAIL accept_timeout: got o_ready=0 for 1000 cycles, need 1");
                    break;
                end
            end
            i_valid = 1'b0;
            if (random_ready) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s drain: got %0d bytes still missing, need 0", name, exp_q.size());
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        compared++;
        if (err_seen != exp_err) begin
            mismatched++;
            $display("FAIL %s err_count: got %0d pulses, need %0d", name, err_seen, exp_err);
        end
        $display("phase %s: queue=%0d errs=%0d/%0d", name, exp_q.size(), err_seen, exp_err);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_valid = 1'b0;
        model_synced = 0;
        frame_buf.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || o_data !== 8'h00 || o_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: got valid=%0b last=%0b data=%02h err=%0b, need all 0",
                     o_valid, o_last, o_data, o_err);
        end
    endtask

    initial begin
        logic [7:0] s[$];
        rst = 1'b0;
        repeat (3) @(posedge clk);
        do_reset();

        s = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
        send_stream(s, -1);
        drain("basic");

        s = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
        send_stream(s, -1);
        drain("zeros");

        s.delete();
        s.push_back(8'hFF);
        for (int v = 1; v <= 254; v++) s.push_back(8'(v));
        s.push_back(8'h00);
        send_stream(s, -1);
        drain("ff_block");

        s = '{8'h04, 8'hAA, 8'h00, 8'h02, 8'h55, 8'h00, 8'h03, 8'h00};
        send_stream(s, -1);
        drain("truncated");

        do_reset();
        s = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
        send_stream(s, 3);
        drain("stall");

        s = '{8'h03, 8'h11};
        send_stream(s, -1);
        repeat (3) @(posedge clk);
        do_reset();
        s = '{8'h22, 8'h02, 8'h33, 8'h00, 8'h03, 8'h11, 8'h22, 8'h00};
        send_stream(s, -1);
        drain("mid_reset");

        random_ready = 1;
        for (int f = 0; f < 40; f++) begin
            int nblk;
            s.delete();
            nblk = $urandom_range(0, 4);
            for (int b = 0; b < nblk; b++) begin
                int c;
                c = ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(1, 8);
                s.push_back(8'(c));
                for (int k = 1; k < c; k++) s.push_back(8'($urandom_range(1, 255)));
            end
            if (s.size() > 1 && $urandom_range(0, 4) == 0) begin
                int cut;
                cut = $urandom_range(1, s.size() - 1);
                while (s.size() > cut) void'(s.pop_back());
            end
            s.push_back(8'h00);
            send_stream(s, -1);
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
